// File: rtl/fc_pkg.sv
// ---------------------------------------------------------------------------
// fc_pkg
// Shared definitions for the flow-control arbiter slice.
//   N_CH / SEL_W  : 32 request channels, 5-bit channel index
//   DW            : payload width per channel
//   chan_data_t   : one channel payload
//   arb_state_t   : arbiter FSM states
//   HOLD_MAX      : longest burst one channel may hold the grant
//                   (only used when FC_ARB_HOLD_EN is defined)
// ---------------------------------------------------------------------------
package fc_pkg;

  localparam int N_CH     = 32;
  localparam int SEL_W    = 5;
  localparam int DW       = 20;
  localparam int HOLD_MAX = 8;

  // Burst counter value reached after HOLD_MAX consecutive grants.
  localparam logic [2:0] HOLD_LAST = 3'(HOLD_MAX - 1);

  typedef logic [DW-1:0] chan_data_t;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

  // Turns a channel index into the one-hot form the encoder consumes.
  function automatic logic [N_CH-1:0] decode_sel(input logic [SEL_W-1:0] sel);
    logic [N_CH-1:0] vec;
    vec      = '0;
    vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter_if
// Bundles the request side and the downstream valid/ready side of the
// round-robin arbiter.
//   req, req_data        : per-channel request and payload (upstream)
//   gnt                  : per-channel accept strobe (to upstream)
//   out_valid/out_ready  : downstream handshake
//   out_sel/out_onehot   : winner index and one-hot form
//   out_data             : winner payload
//   hold                 : burst hold request (FC_ARB_HOLD_EN only)
// Modports: master = arbiter side, slave = the surrounding logic.
// ---------------------------------------------------------------------------
interface rr_arbiter_if;
  import fc_pkg::*;

  logic [N_CH-1:0]              req;
  chan_data_t [N_CH-1:0]        req_data;
  logic [N_CH-1:0]              gnt;
  logic                         out_valid;
  logic                         out_ready;
  logic [SEL_W-1:0]             out_sel;
  logic [N_CH-1:0]              out_onehot;
  chan_data_t                   out_data;
`ifdef FC_ARB_HOLD_EN
  logic                         hold;

  modport master (
    input  req, req_data, out_ready, hold,
    output gnt, out_valid, out_sel, out_onehot, out_data
  );

  modport slave (
    output req, req_data, out_ready, hold,
    input  gnt, out_valid, out_sel, out_onehot, out_data
  );
`else
  modport master (
    input  req, req_data, out_ready,
    output gnt, out_valid, out_sel, out_onehot, out_data
  );

  modport slave (
    output req, req_data, out_ready,
    input  gnt, out_valid, out_sel, out_onehot, out_data
  );
`endif

endinterface

// File: rtl/rr_pick32.sv
// ---------------------------------------------------------------------------
// rr_pick32
// Purely combinational cyclic priority finder.
//   req    : request vector
//   base   : index where the search starts (highest priority)
//   found  : at least one request is set
//   idx    : first set request at or after base, wrapping 31 -> 0
//   onehot : idx as one-hot, zero when nothing is found
// ---------------------------------------------------------------------------
module rr_pick32
  import fc_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] base,
  output logic             found,
  output logic [SEL_W-1:0] idx,
  output logic [N_CH-1:0]  onehot
);

  logic [N_CH-1:0]  rotated;
  logic [SEL_W-1:0] offset;

  // Rotate the request vector so that bit 0 is the channel at base (the
  // 5-bit index sum wraps naturally), then find the lowest set bit. The
  // loop runs downward so the last hit it records is the lowest one.
  always_comb begin
    rotated = '0;
    found   = 1'b0;
    offset  = '0;
    for (int i = 0; i < N_CH; i++) begin
      rotated[i] = req[SEL_W'(i) + base];
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = SEL_W'(i);
      end
    end
  end

  // Undo the rotation: the offset is relative to base.
  assign idx    = offset + base;
  assign onehot = found ? decode_sel(idx) : '0;

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// 32-channel round-robin arbiter feeding the flow-control mux/encode stage.
// One winner per transfer is registered (index, one-hot, payload) and
// offered downstream with valid/ready.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : rr_arbiter_if.master (request side + downstream side)
// Optional feature macro: FC_ARB_HOLD_EN adds the hold input and a burst
// counter that lets one channel keep the grant for up to HOLD_MAX transfers.
// ---------------------------------------------------------------------------
module rr_arbiter
  import fc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  rr_arbiter_if.master bus
);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] sel_q;
  logic [N_CH-1:0]  onehot_q;
  chan_data_t       data_q;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic [N_CH-1:0]  pick_onehot;
  logic [SEL_W-1:0] win_idx;
  logic [N_CH-1:0]  win_onehot;
  logic             handshake;
  logic             load;
  logic             keep;

  // A transfer completes when the held entry is accepted; a new winner can
  // load from IDLE or in the same edge as that completion.
  assign handshake = (state == BUSY) && bus.out_ready;
  assign load      = pick_found && ((state == IDLE) || handshake);

  // After a handshake the search starts just past the channel that was
  // served; from IDLE it starts at the saved rotation pointer.
  assign base = (state == BUSY) ? sel_q + 1'b1 : ptr;

  rr_pick32 u_pick (
    .req    (bus.req),
    .base   (base),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

`ifdef FC_ARB_HOLD_EN
  logic [2:0] burst_cnt;

  // The current channel keeps the grant while it still requests, hold is
  // asserted and it has not yet used up its burst allowance.
  assign keep       = handshake && bus.hold && bus.req[sel_q] &&
                      (burst_cnt != HOLD_LAST);
  assign win_idx    = keep ? sel_q : pick_idx;
  assign win_onehot = keep ? onehot_q : pick_onehot;

  // Burst counter tracks consecutive grants to one channel (count minus
  // one). It rolls over to zero after the forced rotation and clears
  // whenever the winner changes or a load starts from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (load) begin
      if (handshake && (win_idx == sel_q)) begin
        burst_cnt <= burst_cnt + 3'd1;
      end else begin
        burst_cnt <= '0;
      end
    end
  end
`else
  assign keep       = 1'b0;
  assign win_idx    = pick_idx;
  assign win_onehot = pick_onehot;
`endif

  // State register for the IDLE/BUSY controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and grant logic. The grant is suppressed while reset is
  // asserted so nothing upstream believes a payload was taken.
  always_comb begin
    state_next = state;
    bus.gnt    = '0;
    if (load && !rst) begin
      bus.gnt = win_onehot;
    end
    case (state)
      IDLE: begin
        if (load) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (handshake && !load) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output registers and rotation pointer. On a load the winner is
  // captured and the pointer moves just past it; a held re-grant leaves the
  // pointer alone. When the last transfer drains the registers keep their
  // values so the mux select stays put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= '0;
      onehot_q <= '0;
      data_q   <= '0;
      ptr      <= '0;
    end else if (load) begin
      sel_q    <= win_idx;
      onehot_q <= win_onehot;
      data_q   <= bus.req_data[win_idx];
      if (!keep) begin
        ptr <= win_idx + 1'b1;
      end
    end
  end

  assign bus.out_valid  = (state == BUSY);
  assign bus.out_sel    = sel_q;
  assign bus.out_onehot = onehot_q;
  assign bus.out_data   = data_q;

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that sits directly upstream of the 32-channel × 20-bit flow-control mux/encode stage. It accepts up to 32 concurrent request channels and picks one per transfer with rotating priority. It registers the winner's 5-bit index, one-hot vector and 20-bit payload, and presents them downstream with a valid/ready handshake. The 5-bit select output drives the mux select directly. The one-hot output is the encoder's input form.

## Interface
- `N_CH`, 32: channel count; fixed at 32 (5-bit index).
- `DW`, 20: payload width per channel.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req`, in, [31:0]: per-channel request (valid).
- `req_data`, in, [31:0][19:0]: per-channel payload.
- `gnt`, out, [31:0]: one-hot accept strobe. `req[i]&gnt[i]` at a clock edge means channel i's payload was taken.
- `out_valid`, out, 1: registered transfer is present.
- `out_ready`, in, 1: downstream accepts the transfer.
- `out_sel`, out, [4:0]: winner index.
- `out_onehot`, out, [31:0]: winner as a one-hot vector; always equals decode(`out_sel`) while `out_valid`=1.
- `out_data`, out, [19:0]: winner payload.
- `hold`, in, 1: present only with `FC_ARB_HOLD_EN`.

## Operation
- State: `IDLE`, `BUSY`. Rotation pointer `ptr` is [4:0].
- Load condition: `load = |req && (state==IDLE || (out_ready && out_valid))`.
- Search: the winner is the first set `req` bit at index ≥ base, scanning cyclically 31→0. Base is:
  - `ptr` in `IDLE`;
  - `out_sel+1` (mod 32) on a handshake in `BUSY`.
- `gnt` is combinational and one-hot on the winner only when `load` is true; otherwise it is all zero.
- On `load`: capture `out_sel`, `out_onehot` and `out_data`, set `ptr` to the winner+1 (mod 32; 31 wraps to 0), and enter/stay in `BUSY`.
- Handshake with no requests: `out_valid` goes to 0, the state goes to `IDLE`, and `out_sel`/`out_data` hold their last values.
- `BUSY` without `out_ready`: all outputs are stable and `gnt` is 0. `req` changes are ignored until the handshake.
- Only one request is asserted: that channel wins regardless of `ptr`.
- Winner index arithmetic is 5-bit unsigned with natural wrap.

## Timing
- Reset values: `out_valid`=0, `out_sel`=0, `out_onehot`=0, `out_data`=0, `gnt`=0, `ptr`=0, state=`IDLE`.
- Reset mid-transfer drops the held transfer; no `gnt` is issued during reset.
- Latency: a request in `IDLE` at edge k is presented with `out_valid`=1 after edge k (1 cycle).
- Throughput: 1 transfer per cycle while `out_ready`=1 and requests are pending.
- Simultaneous handshake and new requests: the next winner loads in the same edge, and `out_valid` stays 1 with no bubble.
- `gnt` is never asserted to a channel with `req`=0.

## Configuration
- `FC_ARB_HOLD_EN` defined:
  - Adds the `hold` port and a 3-bit burst counter.
  - On a handshake with `hold`=1 and `req[out_sel]`=1, the same channel is re-granted and `ptr` is unchanged.
  - After 8 consecutive grants to one channel, normal rotation is forced for the next load and the counter clears.
  - The counter resets to 0 and clears on any change of winner.
- `FC_ARB_HOLD_EN` undefined: no `hold` port and pure round-robin behaviour.

## Structure
- Shared package `fc_pkg` holds:
  - `N_CH`=32, `SEL_W`=5, `DW`=20;
  - `chan_data_t` (logic [19:0]);
  - `arb_state_t` enum {`IDLE`, `BUSY`};
  - `HOLD_MAX`=8.
- One combinational sub-module, `rr_pick32`: inputs `req` [31:0] and `base` [4:0]; outputs `found`, `idx` [4:0], `onehot` [31:0] (rotate, priority-find, unrotate).

## Test plan
- Reset, then `req`=0x0000_0001 with `req_data[0]`=0xABCDE → `gnt`=0x1 in the load cycle. Next cycle: `out_valid`=1, `out_sel`=0, `out_onehot`=0x1, `out_data`=0xABCDE.
- `req`=0xFFFF_FFFF and `out_ready`=1 held for 33 cycles → `out_sel` sequence 0,1,…,31,0 with `out_valid` continuously 1.
- `req`=0x8000_0001, `ptr`=31 → winner 31, then 0; wrap verified.
- `out_ready`=0 for 5 cycles while `req` toggles → `out_sel`/`out_data` are stable and `gnt`=0 throughout.
- Assert `rst` while `out_valid`=1 → `out_valid`=0 immediately (asynchronous) and `ptr`=0. After release with `req`=0x0000_0004 → `out_sel`=2.
- `FC_ARB_HOLD_EN`: `req`=0x3, `hold`=1 on channel 0 → channel 0 granted 8 times, then channel 1, then channel 0 again.
